carregador_instrucoes: RTL

- Program loader that fills the instruction memory at run time. It is the write side of the processor's read-only instruction fetch path.
- Consumes a byte stream, typically from a UART receiver: a 16-bit word count followed by the instruction words, most significant byte first.
- Assembles each 32-bit instruction and issues one write per word to the instruction memory write port at consecutive addresses.
- Holds the processor in reset for the whole load.

---
 rtl/carregador_instrucoes.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/carregador_instrucoes.sv
// rtl/carregador_instrucoes.sv - run-time instruction memory loader fed by a byte stream
// Optional trailing XOR checksum byte after the data: define CARREGADOR_CHECKSUM_EN.
module carregador_instrucoes #(
  parameter logic [31:0] BASE_END     = 32'd0,
  parameter int unsigned MAX_PALAVRAS = 1025
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        byte_valido,
  input  logic [7:0]  byte_dado,
  output logic        escrita_en,
  output logic [31:0] escrita_endereco,
  output logic [31:0] escrita_instrucao,
  output logic        segura_cpu,
  output logic        ocupado,
  output logic        concluido,
  output logic        erro
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CAB_ALTO  = 3'd1,
    CAB_BAIXO = 3'd2,
    DADOS     = 3'd3,
    CHECK     = 3'd4,
    FIM       = 3'd5
  } t_estado;

  localparam logic [16:0] LP_MAX = 17'(MAX_PALAVRAS);

  t_estado     r_estado;
  logic [15:0] r_total;
  logic [15:0] r_palavras;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_palavra;
  logic        r_escrita_en;
  logic [31:0] r_endereco;
  logic [31:0] r_instrucao;
  logic        r_segura;
  logic        r_ocupado;
  logic        r_concluido;
  logic        r_erro;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0]  r_xor;
  logic        w_ultima;
`endif

  logic [15:0] w_total_novo;
  logic [31:0] w_palavra_nova;

  assign w_total_novo   = {r_total[15:8], byte_dado};
  assign w_palavra_nova = {r_palavra[23:0], byte_dado};
`ifdef CARREGADOR_CHECKSUM_EN
  assign w_ultima       = (r_palavras + 16'd1) == r_total;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= OCIOSO;
      r_total      <= '0;
      r_palavras   <= '0;
      r_byte_idx   <= '0;
      r_palavra    <= '0;
      r_escrita_en <= 1'b0;
      r_endereco   <= '0;
      r_instrucao  <= '0;
      r_segura     <= 1'b0;
      r_ocupado    <= 1'b0;
      r_concluido  <= 1'b0;
      r_erro       <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      r_escrita_en <= 1'b0;
      r_concluido  <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            r_estado   <= CAB_ALTO;
            r_segura   <= 1'b1;
            r_ocupado  <= 1'b1;
            r_erro     <= 1'b0;
            r_total    <= '0;
            r_palavras <= '0;
            r_byte_idx <= '0;
            r_palavra  <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            r_xor      <= '0;
`endif
          end
        end

        CAB_ALTO: begin
          if (byte_valido) begin
            r_total[15:8] <= byte_dado;
            r_estado      <= CAB_BAIXO;
`ifdef CARREGADOR_CHECKSUM_EN
            r_xor         <= r_xor ^ byte_dado;
`endif
          end
        end

        CAB_BAIXO: begin
          if (byte_valido) begin
            r_total[7:0] <= byte_dado;
            r_palavras   <= '0;
            r_byte_idx   <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            r_xor        <= r_xor ^ byte_dado;
`endif
            if (w_total_novo == 16'd0) begin
`ifdef CARREGADOR_CHECKSUM_EN
              r_estado    <= CHECK;
`else
              r_estado    <= FIM;
              r_concluido <= 1'b1;
              r_segura    <= 1'b0;
`endif
            end else if ({1'b0, w_total_novo} > LP_MAX) begin
              r_estado  <= OCIOSO;
              r_erro    <= 1'b1;
              r_segura  <= 1'b0;
              r_ocupado <= 1'b0;
            end else begin
              r_estado <= DADOS;
            end
          end
        end

        DADOS: begin
          // Without a checksum the strobe cycle of the last word lands here with
          // the count already complete; completion is signalled on the cycle after.
          if (r_palavras == r_total) begin
            r_estado    <= FIM;
            r_concluido <= 1'b1;
            r_segura    <= 1'b0;
          end else if (byte_valido) begin
            r_palavra  <= w_palavra_nova;
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef CARREGADOR_CHECKSUM_EN
            r_xor      <= r_xor ^ byte_dado;
`endif
            if (r_byte_idx == 2'd3) begin
              r_escrita_en <= 1'b1;
              r_instrucao  <= w_palavra_nova;
              r_endereco   <= BASE_END + {16'd0, r_palavras};
              r_palavras   <= r_palavras + 16'd1;
`ifdef CARREGADOR_CHECKSUM_EN
              if (w_ultima) begin
                r_estado <= CHECK;
              end
`endif
            end
          end
        end

`ifdef CARREGADOR_CHECKSUM_EN
        CHECK: begin
          if (byte_valido) begin
            if (byte_dado == r_xor) begin
              r_estado    <= FIM;
              r_concluido <= 1'b1;
              r_segura    <= 1'b0;
            end else begin
              r_estado  <= OCIOSO;
              r_erro    <= 1'b1;
              r_segura  <= 1'b0;
              r_ocupado <= 1'b0;
            end
          end
        end
`endif

        FIM: begin
          r_estado  <= OCIOSO;
          r_segura  <= 1'b0;
          r_ocupado <= 1'b0;
        end

        default: begin
          r_estado  <= OCIOSO;
          r_segura  <= 1'b0;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign escrita_en        = r_escrita_en;
  assign escrita_endereco  = r_endereco;
  assign escrita_instrucao = r_instrucao;
  assign segura_cpu        = r_segura;
  assign ocupado           = r_ocupado;
  assign concluido         = r_concluido;
  assign erro              = r_erro;

endmodule
